// File: rtl/axi_mem_slave.sv
// ============================================================================
//  Module      : axi_mem_slave
//  Description : AXI4 slave endpoint backed by word-addressed on-chip RAM.
//                Independent write and read FSMs, INCR bursts, full-width beats.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_mem_slave #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 32,
  parameter int          ID_W_WIDTH = 4,
  parameter int          ID_R_WIDTH = 4,
  parameter int          MEM_DEPTH  = 1024,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  // AW channel
  input  logic [ID_W_WIDTH-1:0]   s_axi_awid_i,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr_i,
  input  logic [7:0]              s_axi_awlen_i,
  input  logic                    s_axi_awvalid_i,
  output logic                    s_axi_awready_o,
  // W channel
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb_i,
  input  logic                    s_axi_wlast_i,
  input  logic                    s_axi_wvalid_i,
  output logic                    s_axi_wready_o,
  // B channel
  output logic [ID_W_WIDTH-1:0]   s_axi_bid_o,
  output logic [1:0]              s_axi_bresp_o,
  output logic                    s_axi_bvalid_o,
  input  logic                    s_axi_bready_i,
  // AR channel
  input  logic [ID_R_WIDTH-1:0]   s_axi_arid_i,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr_i,
  input  logic [7:0]              s_axi_arlen_i,
  input  logic                    s_axi_arvalid_i,
  output logic                    s_axi_arready_o,
  // R channel
  output logic [ID_R_WIDTH-1:0]   s_axi_rid_o,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata_o,
  output logic [1:0]              s_axi_rresp_o,
  output logic                    s_axi_rlast_o,
  output logic                    s_axi_rvalid_o,
  input  logic                    s_axi_rready_i
);

  localparam int                  c_nbytes = DATA_WIDTH / 8;
  localparam int                  c_shift  = $clog2(c_nbytes);
  localparam int                  c_idx_w  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] c_base  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   c_depth = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [c_idx_w-1:0]    c_last_idx = c_idx_w'(MEM_DEPTH - 1);
  localparam logic [1:0]          c_okay   = 2'b00;
  localparam logic [1:0]          c_slverr = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  logic [DATA_WIDTH-1:0] ram_q [MEM_DEPTH];

  function automatic logic [c_idx_w-1:0] idx_next(input logic [c_idx_w-1:0] idx);
    return (idx == c_last_idx) ? '0 : idx + 1'b1;
  endfunction

  // Address decode: word index plus out-of-range flag for a burst start address
  logic [ADDR_WIDTH-1:0] w_aw_word, w_ar_word;
  logic [c_idx_w-1:0]    w_aw_idx, w_ar_idx;
  logic                  w_aw_oor, w_ar_oor;

  assign w_aw_word = (s_axi_awaddr_i - c_base) >> c_shift;
  assign w_ar_word = (s_axi_araddr_i - c_base) >> c_shift;
  assign w_aw_idx  = w_aw_word[c_idx_w-1:0];
  assign w_ar_idx  = w_ar_word[c_idx_w-1:0];
  assign w_aw_oor  = (s_axi_awaddr_i < c_base) || ({1'b0, w_aw_word} >= c_depth);
  assign w_ar_oor  = (s_axi_araddr_i < c_base) || ({1'b0, w_ar_word} >= c_depth);

  // ---------------------------------------------------------------- write path
  w_state_e              w_state_q;
  logic                  awready_q, wready_q, bvalid_q, w_oor_q, w_err_q;
  logic [1:0]            bresp_q;
  logic [ID_W_WIDTH-1:0] w_id_q;
  logic [c_idx_w-1:0]    w_idx_q;
  logic [7:0]            w_len_q, w_cnt_q;
  logic                  w_last_beat, w_hs, w_we, w_lerr;

  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_hs        = (w_state_q == W_DATA) && s_axi_wvalid_i && wready_q;
  assign w_lerr      = (s_axi_wlast_i != w_last_beat);
  assign w_we        = w_hs && !w_oor_q && !ARESET;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= c_okay;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (s_axi_awvalid_i && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_id_q    <= s_axi_awid_i;
            w_idx_q   <= w_aw_idx;
            w_len_q   <= s_axi_awlen_i;
            w_oor_q   <= w_aw_oor;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_idx_q <= idx_next(w_idx_q);
            w_cnt_q <= w_cnt_q + 8'd1;
            if (w_lerr) w_err_q <= 1'b1;
            // The beat count, not WLAST, decides when the burst ends
            if (w_last_beat) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= (w_oor_q || w_err_q || w_lerr) ? c_slverr : c_okay;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready_i) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_we) begin
      for (int b = 0; b < c_nbytes; b++) begin
        if (s_axi_wstrb_i[b]) ram_q[w_idx_q][8*b +: 8] <= s_axi_wdata_i[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read path
  r_state_e              r_state_q;
  logic                  arready_q, rvalid_q, rlast_q, r_oor_q;
  logic [ID_R_WIDTH-1:0] r_id_q;
  logic [c_idx_w-1:0]    r_idx_q, w_r_idx_nxt;
  logic [7:0]            r_len_q, r_cnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign w_r_idx_nxt = idx_next(r_idx_q);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      r_cnt_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (s_axi_arvalid_i && arready_q) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            r_id_q    <= s_axi_arid_i;
            r_len_q   <= s_axi_arlen_i;
            r_oor_q   <= w_ar_oor;
            r_idx_q   <= w_ar_idx;
            r_cnt_q   <= '0;
            rlast_q   <= (s_axi_arlen_i == 8'd0);
            rdata_q   <= w_ar_oor ? '0 : ram_q[w_ar_idx];
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid_q && s_axi_rready_i) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              // Prefetch the next word on the accepting edge for 1 beat/cycle
              r_idx_q <= w_r_idx_nxt;
              r_cnt_q <= r_cnt_q + 8'd1;
              rlast_q <= ((r_cnt_q + 8'd1) == r_len_q);
              rdata_q <= r_oor_q ? '0 : ram_q[w_r_idx_nxt];
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready_o = awready_q;
  assign s_axi_wready_o  = wready_q;
  assign s_axi_bid_o     = w_id_q;
  assign s_axi_bresp_o   = bresp_q;
  assign s_axi_bvalid_o  = bvalid_q;
  assign s_axi_arready_o = arready_q;
  assign s_axi_rid_o     = r_id_q;
  assign s_axi_rdata_o   = rdata_q;
  assign s_axi_rresp_o   = r_oor_q ? c_slverr : c_okay;
  assign s_axi_rlast_o   = rlast_q;
  assign s_axi_rvalid_o  = rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
// ============================================================================
//  Module      : tb_axi_mem_slave
//  Description : Scenario bench for axi_mem_slave with B/R scoreboards and a
//                reference memory model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi_mem_slave;

  localparam int DEPTH = 1024;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  awid = '0, arid = '0;
  logic [15:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [3:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  always #5 ACLK = ~ACLK;

  axi_mem_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axi_awid_i(awid), .s_axi_awaddr_i(awaddr), .s_axi_awlen_i(awlen),
    .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
    .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wlast_i(wlast),
    .s_axi_wvalid_i(wvalid), .s_axi_wready_o(wready),
    .s_axi_bid_o(bid), .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid),
    .s_axi_bready_i(bready),
    .s_axi_arid_i(arid), .s_axi_araddr_i(araddr), .s_axi_arlen_i(arlen),
    .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
    .s_axi_rid_o(rid), .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp),
    .s_axi_rlast_o(rlast), .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready)
  );

  typedef struct packed {logic [3:0] id; logic [1:0] resp;} bexp_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp; logic [31:0] data; logic last;} rexp_t;

  bexp_t       bq[$];
  rexp_t       rq[$];
  logic [31:0] model [DEPTH];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic axi_write(input logic [15:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [31:0] d0, input logic [31:0] dinc,
                           input logic [3:0] strb, input bit early);
    int idx, wd;
    bit oor, perr;
    logic [31:0] d;
    logic wl;
    bexp_t exp;
    idx = int'(addr) >> 2;
    oor = (idx >= DEPTH);
    perr = 1'b0;
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1; wd = 0;
    while (awready !== 1'b1 && wd < 100) begin @(posedge ACLK); #1; wd++; end
    if (awready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL aw_timeout: awready=%b required 1", awready);
      awvalid = 1'b0;
      return;
    end
    @(posedge ACLK); #1;
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      d  = d0 + dinc * b;
      wl = early ? (b == 0) : (b == int'(len));
      if (wl != (b == int'(len))) perr = 1'b1;
      wdata = d; wstrb = strb; wlast = wl; wvalid = 1'b1; wd = 0;
      while (wready !== 1'b1 && wd < 100) begin @(posedge ACLK); #1; wd++; end
      if (wready !== 1'b1) begin
        n_tests++; n_fail++;
        $display("FAIL w_timeout: beat %0d wready=%b required 1", b, wready);
        wvalid = 1'b0;
        return;
      end
      @(posedge ACLK); #1;
      if (!oor)
        for (int k = 0; k < 4; k++)
          if (strb[k]) model[(idx + b) % DEPTH][8*k +: 8] = d[8*k +: 8];
    end
    wvalid = 1'b0; wlast = 1'b0;
    bq.push_back('{id: id, resp: (oor || perr) ? 2'b10 : 2'b00});
    n_tests++;
    if (bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL b_latency: bvalid=%b required 1 right after last W beat", bvalid);
    end
    bready = 1'b1; wd = 0;
    while (bvalid !== 1'b1 && wd < 100) begin @(posedge ACLK); #1; wd++; end
    exp = bq.pop_front();
    n_tests++;
    if (bvalid !== 1'b1 || {bid, bresp} !== {exp.id, exp.resp}) begin
      n_fail++;
      $display("FAIL b_resp: bvalid=%b bid=%h bresp=%b required bid=%h bresp=%b",
               bvalid, bid, bresp, exp.id, exp.resp);
    end
    @(posedge ACLK); #1;
    bready = 1'b0;
    n_tests++;
    if (awready !== 1'b1 || bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b_done: awready=%b bvalid=%b required 1 0", awready, bvalid);
    end
  endtask

  task automatic push_read(input logic [15:0] addr, input logic [3:0] id, input logic [7:0] len);
    int idx;
    bit oor;
    idx = int'(addr) >> 2;
    oor = (idx >= DEPTH);
    for (int b = 0; b <= int'(len); b++)
      rq.push_back('{id: id, resp: oor ? 2'b10 : 2'b00,
                     data: oor ? 32'h0 : model[(idx + b) % DEPTH], last: (b == int'(len))});
  endtask

  task automatic issue_ar(input logic [15:0] addr, input logic [3:0] id, input logic [7:0] len,
                          output bit ok);
    int wd;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1; wd = 0;
    while (arready !== 1'b1 && wd < 100) begin @(posedge ACLK); #1; wd++; end
    ok = (arready === 1'b1);
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL ar_timeout: arready=%b required 1", arready);
      arvalid = 1'b0;
      rq.delete();
      return;
    end
    @(posedge ACLK); #1;
    arvalid = 1'b0;
    n_tests++;
    if (rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL r_latency: rvalid=%b required 1 one cycle after AR", rvalid);
    end
  endtask

  task automatic axi_read(input logic [15:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input bit toggle);
    int beats, cyc;
    bit ok, stalled;
    rexp_t exp, held, cur;
    push_read(addr, id, len);
    issue_ar(addr, id, len, ok);
    if (!ok) return;
    beats = 0; cyc = 0; stalled = 1'b0;
    while (beats <= int'(len) && cyc < 2000) begin
      rready = toggle ? (cyc % 2 == 0) : 1'b1;
      cur = '{id: rid, resp: rresp, data: rdata, last: rlast};
      if (stalled) begin
        n_tests++;
        if (rvalid !== 1'b1 || cur !== held) begin
          n_fail++;
          $display("FAIL r_stall_hold: rvalid=%b fields=%h required 1 %h", rvalid, cur, held);
        end
      end
      stalled = 1'b0;
      if (rvalid === 1'b1 && rready) begin
        exp = rq.pop_front();
        n_tests++;
        if (cur !== exp) begin
          n_fail++;
          $display("FAIL r_beat%0d: id=%h resp=%b data=%h last=%b required id=%h resp=%b data=%h last=%b",
                   beats, rid, rresp, rdata, rlast, exp.id, exp.resp, exp.data, exp.last);
        end
        beats++;
      end else if (rvalid === 1'b1) begin
        held = cur;
        stalled = 1'b1;
      end
      @(posedge ACLK); #1;
      cyc++;
    end
    rready = 1'b0;
    n_tests++;
    if (beats <= int'(len) || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL r_complete: beats=%0d rvalid=%b required %0d 0", beats, rvalid, int'(len) + 1);
      rq.delete();
    end
    if (!toggle) begin
      n_tests++;
      if (cyc != int'(len) + 1) begin
        n_fail++;
        $display("FAIL r_throughput: cycles=%0d required %0d", cyc, int'(len) + 1);
      end
    end
  endtask

  task automatic test_reset;
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    n_tests++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: aw/w/b/ar/r/rlast=%b required 000000",
               {awready, wready, bvalid, arready, rvalid, rlast});
    end
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    n_tests++;
    if ({awready, arready} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release: awready/arready=%b required 11", {awready, arready});
    end
  endtask

  task automatic test_single;
    axi_write(16'h0010, 4'd3, 8'd0, 32'hDEADBEEF, 32'h0, 4'hF, 1'b0);
    axi_read(16'h0010, 4'd5, 8'd0, 1'b0);
  endtask

  task automatic test_strobes;
    axi_write(16'h0020, 4'd1, 8'd0, 32'h11223344, 32'h0, 4'hF, 1'b0);
    axi_write(16'h0020, 4'd2, 8'd0, 32'hAABBCCDD, 32'h0, 4'b0101, 1'b0);
    axi_read(16'h0020, 4'd6, 8'd0, 1'b0);
  endtask

  task automatic test_burst_backpressure;
    axi_write(16'h0040, 4'd4, 8'd3, 32'd1, 32'd1, 4'hF, 1'b0);
    axi_read(16'h0040, 4'd7, 8'd3, 1'b1);
    axi_read(16'h0040, 4'd8, 8'd3, 1'b0);
  endtask

  task automatic test_out_of_range;
    axi_write(16'h0000, 4'd9, 8'd0, 32'hCAFEF00D, 32'h0, 4'hF, 1'b0);
    axi_read(16'h1000, 4'd4, 8'd0, 1'b0);
    axi_write(16'h1000, 4'd6, 8'd0, 32'h0BADBEEF, 32'h0, 4'hF, 1'b0);
    axi_read(16'h0000, 4'd2, 8'd0, 1'b0);
  endtask

  task automatic test_wlast_error;
    axi_write(16'h0080, 4'd2, 8'd1, 32'h5000, 32'h1, 4'hF, 1'b1);
    axi_read(16'h0080, 4'd3, 8'd1, 1'b0);
  endtask

  task automatic test_wrap;
    axi_write(16'h0FFC, 4'd1, 8'd1, 32'h77770000, 32'h1, 4'hF, 1'b0);
    axi_read(16'h0FFC, 4'd1, 8'd1, 1'b0);
  endtask

  task automatic test_reset_mid_burst;
    int beats, cyc, wd;
    bit ok;
    rexp_t exp, cur;
    axi_write(16'h0100, 4'd1, 8'd7, 32'h100, 32'h1, 4'hF, 1'b0);
    push_read(16'h0100, 4'd10, 8'd7);
    issue_ar(16'h0100, 4'd10, 8'd7, ok);
    if (!ok) return;
    rready = 1'b1; beats = 0; cyc = 0;
    while (beats < 2 && cyc < 100) begin
      if (rvalid === 1'b1) begin
        cur = '{id: rid, resp: rresp, data: rdata, last: rlast};
        exp = rq.pop_front();
        n_tests++;
        if (cur !== exp) begin
          n_fail++;
          $display("FAIL rst_burst_beat%0d: fields=%h required %h", beats, cur, exp);
        end
        beats++;
      end
      @(posedge ACLK); #1;
      cyc++;
    end
    rready = 1'b0;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    rq.delete();
    n_tests++;
    if ({rvalid, rlast, arready} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid_burst: rvalid/rlast/arready=%b required 000", {rvalid, rlast, arready});
    end
    wd = 0;
    while (arready !== 1'b1 && wd < 20) begin @(posedge ACLK); #1; wd++; end
    n_tests++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_recover: arready=%b rvalid=%b required 1 0", arready, rvalid);
    end
    axi_read(16'h0104, 4'd11, 8'd3, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_strobes();
    test_burst_backpressure();
    test_out_of_range();
    test_wlast_error();
    test_wrap();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
